// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer
// and the sequence-detector stages it feeds.
package ser_pkg;
  typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t;
  localparam int   SER_WIDTH    = 8;
  localparam logic SER_IDLE_BIT = 1'b0;
endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word hold buffer
// so back-to-back words leave without an idle bit.
import ser_pkg::*;

module bit_serializer #(
  parameter int   WIDTH     = SER_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic hold_full, hold_full_n;
  logic sout_n, sv_n;
  logic xfer;
  logic [WIDTH-1:0] src;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = !hold_full;
  assign busy      = (state == SER_SHIFT) || hold_full;
  assign xfer      = din_valid && din_ready;
  assign src       = hold_full ? hold : din;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    hold_n      = hold;
    hold_full_n = hold_full;
    sout_n      = sout;
    sv_n        = sout_valid;
    if (clr) begin
      state_n     = SER_IDLE;
      cnt_n       = '0;
      sh_n        = '0;
      hold_full_n = 1'b0;
      sout_n      = IDLE_BIT;
      sv_n        = 1'b0;
    end else begin
      unique case (state)
        SER_IDLE: begin
          if (xfer) begin
            state_n = SER_SHIFT;
            cnt_n   = '0;
            sh_n    = advance(din);
            sout_n  = first_bit(din);
            sv_n    = 1'b1;
          end
        end
        SER_SHIFT: begin
          if (cnt > LAST) begin
            state_n     = SER_IDLE;
            cnt_n       = '0;
            hold_full_n = 1'b0;
            sout_n      = IDLE_BIT;
            sv_n        = 1'b0;
          end else if (cnt == LAST) begin
            // hold word wins over a fresh one; empty both -> idle
            if (hold_full || xfer) begin
              cnt_n       = '0;
              sh_n        = advance(src);
              sout_n      = first_bit(src);
              hold_full_n = 1'b0;
            end else begin
              state_n = SER_IDLE;
              cnt_n   = '0;
              sout_n  = IDLE_BIT;
              sv_n    = 1'b0;
            end
          end else begin
            cnt_n  = cnt + CW'(1);
            sh_n   = advance(sh);
            sout_n = first_bit(sh);
            if (xfer) begin
              hold_n      = din;
              hold_full_n = 1'b1;
            end
          end
        end
        default: begin
          state_n = SER_IDLE;
          sv_n    = 1'b0;
          sout_n  = IDLE_BIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SER_IDLE;
      cnt        <= '0;
      sh         <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      sout       <= sout_n;
      sout_valid <= sv_n;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and
// LSB-first instances, streaming, backpressure, rst, clr.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready, sout, sout_valid, busy;

  logic [7:0] dinl = '0;
  logic dinl_valid = 1'b0;
  logic dinl_ready, soutl, soutl_valid, busyl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit q0[$];
  bit q1[$];
  int run = 0;
  int max_run = 0;
  int hits = 0;
  int nbits = 0;
  logic [3:0] det = '0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clr(clr),
    .din(dinl), .din_valid(dinl_valid), .din_ready(dinl_ready),
    .sout(soutl), .sout_valid(soutl_valid), .busy(busyl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sout_valid) begin
      run++;
      if (run > max_run) max_run = run;
      det = {det[2:0], sout};
      nbits++;
      if (nbits >= 4 && det == 4'b1011) hits++;
      if (q0.size() == 0) check("extra_bit_msb", q0.size(), 1);
      else check("bit_msb", sout, q0.pop_front());
    end else begin
      run = 0;
    end
    if (soutl_valid) begin
      if (q1.size() == 0) check("extra_bit_lsb", q1.size(), 1);
      else check("bit_lsb", soutl, q1.pop_front());
    end
  end

  // call at a negedge; returns at the negedge after acceptance
  task automatic send(input bit sel, input logic [7:0] w, output int e);
    int n;
    n = 0;
    e = -1;
    if (!sel) begin din = w; din_valid = 1'b1; end
    else begin dinl = w; dinl_valid = 1'b1; end
    #1;
    while (((!sel) ? din_ready : dinl_ready) == 1'b0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout", n, 0);
    end else begin
      e = cyc;
      for (int i = 0; i < 8; i++) begin
        if (!sel) q0.push_back(w[7-i]);
        else q1.push_back(w[i]);
      end
    end
    @(negedge clk);
    if (!sel) din_valid = 1'b0;
    else dinl_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, ec;
    #1;
    check("rst_sout_valid", sout_valid, 0);
    check("rst_sout", sout, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_lsb_valid", soutl_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single word, MSB first
    send(0, 8'hB0, ea);
    repeat (8) @(posedge clk);
    #1;
    check("single_end_valid", sout_valid, 0);
    check("single_end_sout", sout, 0);
    check("single_end_busy", busy, 0);
    check("single_drain", q0.size(), 0);
    @(negedge clk);

    // single word, LSB first
    send(1, 8'h0D, ea);
    repeat (8) @(posedge clk);
    #1;
    check("lsb_end_valid", soutl_valid, 0);
    check("lsb_end_busy", busyl, 0);
    check("lsb_drain", q1.size(), 0);
    @(negedge clk);

    // back-to-back, detector on the stream
    max_run = 0; hits = 0; nbits = 0; det = '0;
    send(0, 8'hB5, ea);
    send(0, 8'h6D, eb);
    check("b2b_accept_gap", eb - ea, 1);
    repeat (17) @(posedge clk);
    #1;
    check("b2b_run", max_run, 16);
    check("b2b_hits_1011", hits, 3);
    check("b2b_drain", q0.size(), 0);
    check("b2b_busy", busy, 0);
    @(negedge clk);

    // backpressure with din_valid held high
    max_run = 0;
    send(0, 8'hC3, ea);
    send(0, 8'h5A, eb);
    #1;
    check("bp_ready_low", din_ready, 0);
    send(0, 8'h96, ec);
    check("bp_b_edge", eb - ea, 1);
    check("bp_c_edge", ec - ea, 9);
    repeat (16) @(posedge clk);
    #1;
    check("bp_run", max_run, 24);
    check("bp_drain", q0.size(), 0);
    @(negedge clk);

    // async reset mid-word
    send(0, 8'hFF, ea);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", sout_valid, 0);
    check("mid_rst_sout", sout, 0);
    check("mid_rst_ready", din_ready, 1);
    check("mid_rst_busy", busy, 0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'h81, ea);
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_drain", q0.size(), 0);
    check("post_rst_valid", sout_valid, 0);
    @(negedge clk);

    // clr with hold full and a word offered
    send(0, 8'hF0, ea);
    send(0, 8'h0F, eb);
    din = 8'hAA;
    din_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_valid", sout_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_ready", din_ready, 1);
    q0.delete();
    @(negedge clk);
    clr = 1'b0;
    din_valid = 1'b0;

    // clr beats a transfer offered in idle
    @(negedge clk);
    din = 8'h55;
    din_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_idle_valid", sout_valid, 0);
    check("clr_idle_busy", busy, 0);
    @(negedge clk);
    clr = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("clr_word_dropped", sout_valid, 0);
    check("final_queue", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stages. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single serial line, with a qualifying valid.
- A one-word holding buffer lets the producer hand over the next word while the current one is shifting. Back-to-back words then leave with no idle bit between them.
- The detector consumes sout directly.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on sout while sout_valid=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear; discards the shifter and hold contents.
- din  input  WIDTH  parallel word.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit, registered.
- sout_valid  output  1  sout carries a data bit, registered.
- busy  output  1  shifter active or hold buffer occupied.

Behaviour:
- Reset (rst=1, async): state=IDLE, hold empty, bit counter=0, sout=IDLE_BIT, sout_valid=0, din_ready=1, busy=0.
- Transfer: occurs at a rising edge when din_valid && din_ready. din must be stable while din_valid=1 and din_ready=0.
- din_ready = !hold_full. It is a function of registered state only. There is no combinational din_valid→din_ready path.
- Shift register and counter:
  - Counter width is $clog2(WIDTH).
  - Bit order follows MSB_FIRST.
  - Unused counter codes never occur; if reached, return to IDLE.
- States:
  - IDLE: sout_valid=0, sout=IDLE_BIT.
    - A transfer loads din straight into the shifter and drives its first bit at the same edge.
    - Next state SHIFT, counter=0.
  - SHIFT: each edge advances to the next bit; sout_valid=1.
    - A transfer at this edge goes to the hold buffer, except when the counter is at its last bit with the hold empty (see last-bit rule below).
- Last bit (counter=WIDTH-1) at an edge, priority order:
  - (1) Hold full: hold moves to shifter, hold empties, counter=0, stay SHIFT.
  - (2) Transfer this edge (hold empty): din loads straight into shifter, counter=0, stay SHIFT.
  - (3) Otherwise: go to IDLE, sout_valid=0, sout=IDLE_BIT.
- Latency: a word accepted at edge k drives bit i on sout during the cycle after edge k+i. This holds when the word goes straight into the shifter. A held word starts in the cycle after the edge at which the previous word's last bit completes.
- Gapless streaming: when each word is offered by the previous word's last-bit edge at the latest, sout_valid stays 1 continuously.
- Throughput: maximum one word per WIDTH cycles sustained. A burst of 2 words is absorbed without backpressure.
- clr=1 at an edge: same end state as reset, except it is synchronous. clr has priority over any transfer at that edge; the offered word is not accepted.
- busy = (state==SHIFT) || hold_full.
- Reset mid-word: the partial word is dropped and sout_valid falls immediately. There is no resumption after reset deassertion.

Decomposition:
- Package ser_pkg holds:
  - typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t;
  - localparam defaults for WIDTH and IDLE_BIT, shared with the detector bench.
- No sub-module. Shifter, hold register, counter and FSM sit in one module.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: din=8'hB0 accepted at edge 0 → sout=1,0,1,1,0,0,0,0 over cycles 1-8 with sout_valid=1. Cycle 9: sout_valid=0, sout=0, busy=0.
- LSB first, MSB_FIRST=0: din=8'h0D → sout=1,0,1,1,0,0,0,0.
- Back-to-back words: 8'hB5 then 8'h6D, each offered as soon as ready →
  - sout_valid high for 16 consecutive cycles;
  - sout stream 10110101 01101101;
  - feeding the stream to the 1011 detector yields 3 matches.
- Backpressure, three words A, B, C with din_valid held high:
  - A accepted at edge 0, B at edge 1;
  - din_ready=0 from edge 1 to edge 8;
  - din_ready=1 after edge 8, C accepted at edge 9;
  - output has no gaps and C is not lost.
- Reset mid-word: rst asserted asynchronously after bit 3 of 8'hFF → sout_valid=0 and din_ready=1 immediately. The next word shifts out from its first bit.
- clr with hold full and din_valid=1: state goes to IDLE, hold empties, the offered word is not accepted. din_ready=1 in the next cycle.
